// File: rtl/integer_execute.sv
// integer_execute: single-cycle ALU/branch stage with registered broadcast, fetch redirect and a ROB writeback FIFO
module integer_execute #(
  parameter int ROB_ID_WIDTH = 5,
  parameter int XLEN = 32,
  parameter int WB_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  output logic                    issue_ready,
  input  logic                    issue_valid,
  input  logic [ROB_ID_WIDTH-1:0] issue_rob_id,
  input  logic [XLEN-1:0]         issue_src1_data,
  input  logic [XLEN-1:0]         issue_src2_data,
  input  logic [XLEN-1:0]         issue_imm,
  input  logic [XLEN-1:0]         issue_pc,
  input  logic [2:0]              issue_funct3,
  input  logic                    issue_is_r_type,
  input  logic                    issue_is_i_type,
  input  logic                    issue_is_u_type,
  input  logic                    issue_is_b_type,
  input  logic                    issue_is_j_type,
  input  logic                    issue_is_sub,
  input  logic                    issue_is_sra_srai,
  input  logic                    issue_is_lui,
  input  logic                    issue_is_jalr,
  input  logic                    issue_br_dir_pred,
  input  logic [XLEN-1:0]         issue_br_target_pred,
  output logic                    alu_broadcast_valid,
  output logic [ROB_ID_WIDTH-1:0] alu_broadcast_rob_id,
  output logic [XLEN-1:0]         alu_broadcast_reg_data,
  output logic                    fetch_redirect_valid,
  output logic [XLEN-1:0]         fetch_redirect_pc,
  input  logic                    flush,
  output logic                    rob_wb_valid,
  input  logic                    rob_wb_ready,
  output logic [ROB_ID_WIDTH-1:0] rob_wb_rob_id,
  output logic                    rob_wb_mispredict
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] opb, alu, res, target, pc4, jsum;
  logic [4:0] sh;
  logic beq, blt, bltu, taken, is_br, misp, accept, pop, full;
  logic [ROB_ID_WIDTH-1:0] wb_id [WB_DEPTH];
  logic wb_mp [WB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic unused_i_type;
  assign unused_i_type = issue_is_i_type;
  always_comb begin
    opb = issue_is_r_type ? issue_src2_data : issue_imm;
    sh = opb[4:0];
    pc4 = issue_pc + XLEN'(4);
    case (issue_funct3)
      3'b000: alu = (issue_is_r_type && issue_is_sub) ? issue_src1_data - opb : issue_src1_data + opb;
      3'b001: alu = issue_src1_data << sh;
      3'b010: alu = XLEN'($signed(issue_src1_data) < $signed(opb));
      3'b011: alu = XLEN'(issue_src1_data < opb);
      3'b100: alu = issue_src1_data ^ opb;
      3'b101: alu = issue_is_sra_srai ? XLEN'($signed(issue_src1_data) >>> sh) : issue_src1_data >> sh;
      3'b110: alu = issue_src1_data | opb;
      default: alu = issue_src1_data & opb;
    endcase
    res = issue_is_b_type ? '0 :
          (issue_is_j_type || issue_is_jalr) ? pc4 :
          issue_is_u_type ? (issue_is_lui ? issue_imm : issue_pc + issue_imm) : alu;
    beq = issue_src1_data == issue_src2_data;
    blt = $signed(issue_src1_data) < $signed(issue_src2_data);
    bltu = issue_src1_data < issue_src2_data;
    // funct3[0] inverts the base condition: eq/ne, lt/ge, ltu/geu
    taken = issue_is_j_type || issue_is_jalr ||
            (issue_is_b_type && ((issue_funct3[2] ? (issue_funct3[1] ? bltu : blt) : beq) ^ issue_funct3[0]));
    jsum = issue_src1_data + issue_imm;
    target = issue_is_jalr ? {jsum[XLEN-1:1], 1'b0} : issue_pc + issue_imm;
    is_br = issue_is_b_type || issue_is_j_type || issue_is_jalr;
    misp = is_br && ((taken != issue_br_dir_pred) || (taken && target != issue_br_target_pred));
  end
  assign rob_wb_valid = count != '0;
  assign pop = rob_wb_valid && rob_wb_ready;
  assign full = count == CW'(WB_DEPTH);
  assign issue_ready = !full || pop;
  assign accept = issue_valid && issue_ready && !flush;
  assign rob_wb_rob_id = wb_id[rd_ptr];
  assign rob_wb_mispredict = wb_mp[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      alu_broadcast_valid <= 1'b0;
      alu_broadcast_rob_id <= '0;
      alu_broadcast_reg_data <= '0;
      fetch_redirect_valid <= 1'b0;
      fetch_redirect_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_id[i] <= '0;
        wb_mp[i] <= 1'b0;
      end
    end else begin
      alu_broadcast_valid <= accept;
      fetch_redirect_valid <= accept && misp;
      if (accept) begin
        alu_broadcast_rob_id <= issue_rob_id;
        alu_broadcast_reg_data <= res;
        fetch_redirect_pc <= taken ? target : pc4;
        wb_id[wr_ptr] <= issue_rob_id;
        wb_mp[wr_ptr] <= misp;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_integer_execute.sv
// tb_integer_execute: directed and randomized checks of integer_execute against a behavioural model
module tb_integer_execute;
  typedef struct {
    logic [4:0]  id;
    logic [31:0] s1, s2, imm, pc, ptgt;
    logic [2:0]  f3;
    logic r, i, u, b, j, sub, sra, lui, jalr, pred;
  } instr_t;
  typedef struct { logic [4:0] id; logic mp; } wb_t;
  logic clk = 0, rst_aL = 0;
  logic issue_ready, issue_valid = 0, flush = 0, rob_wb_ready = 0;
  logic alu_broadcast_valid, fetch_redirect_valid, rob_wb_valid, rob_wb_mispredict;
  logic [4:0] alu_broadcast_rob_id, rob_wb_rob_id;
  logic [31:0] alu_broadcast_reg_data, fetch_redirect_pc;
  instr_t cur = '{default: '0};
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  integer_execute dut (
    .clk(clk), .rst_aL(rst_aL), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_rob_id(cur.id), .issue_src1_data(cur.s1), .issue_src2_data(cur.s2),
    .issue_imm(cur.imm), .issue_pc(cur.pc), .issue_funct3(cur.f3),
    .issue_is_r_type(cur.r), .issue_is_i_type(cur.i), .issue_is_u_type(cur.u),
    .issue_is_b_type(cur.b), .issue_is_j_type(cur.j), .issue_is_sub(cur.sub),
    .issue_is_sra_srai(cur.sra), .issue_is_lui(cur.lui), .issue_is_jalr(cur.jalr),
    .issue_br_dir_pred(cur.pred), .issue_br_target_pred(cur.ptgt),
    .alu_broadcast_valid(alu_broadcast_valid), .alu_broadcast_rob_id(alu_broadcast_rob_id),
    .alu_broadcast_reg_data(alu_broadcast_reg_data), .fetch_redirect_valid(fetch_redirect_valid),
    .fetch_redirect_pc(fetch_redirect_pc), .flush(flush), .rob_wb_valid(rob_wb_valid),
    .rob_wb_ready(rob_wb_ready), .rob_wb_rob_id(rob_wb_rob_id), .rob_wb_mispredict(rob_wb_mispredict)
  );
  function automatic instr_t mk_alu(bit r, logic [2:0] f3, logic [31:0] s1, logic [31:0] s2imm, bit alt);
    instr_t x = '{default: '0};
    x.r = r; x.i = !r; x.f3 = f3; x.s1 = s1;
    if (r) x.s2 = s2imm; else x.imm = s2imm;
    x.sub = alt && f3 == 3'd0; x.sra = alt && f3 == 3'd5;
    return x;
  endfunction
  function automatic instr_t mk_u(bit lui, logic [31:0] imm, logic [31:0] pc);
    instr_t x = '{default: '0};
    x.u = 1; x.lui = lui; x.imm = imm; x.pc = pc;
    return x;
  endfunction
  function automatic instr_t mk_b(logic [2:0] f3, logic [31:0] s1, logic [31:0] s2, logic [31:0] pc,
                                  logic [31:0] imm, bit pred, logic [31:0] ptgt);
    instr_t x = '{default: '0};
    x.b = 1; x.f3 = f3; x.s1 = s1; x.s2 = s2; x.pc = pc; x.imm = imm; x.pred = pred; x.ptgt = ptgt;
    return x;
  endfunction
  function automatic instr_t mk_jmp(bit jalr, logic [31:0] s1, logic [31:0] imm, logic [31:0] pc,
                                    bit pred, logic [31:0] ptgt);
    instr_t x = '{default: '0};
    x.j = !jalr; x.jalr = jalr; x.i = jalr; x.s1 = s1; x.imm = imm; x.pc = pc; x.pred = pred; x.ptgt = ptgt;
    return x;
  endfunction
  // Reference semantics: result, whether fetch must be redirected, and where to
  function automatic void ref_exec(input instr_t x, output logic [31:0] res, output logic mp, output logic [31:0] rpc);
    bit [31:0] a = x.s1, o = x.r ? x.s2 : x.imm, tgt;
    int sh = int'(o % 32);
    bit tk = 0;
    case (x.f3)
      0: res = (x.r && x.sub) ? a - o : a + o;
      1: res = a << sh;
      2: res = (int'(a) < int'(o)) ? 1 : 0;
      3: res = (a < o) ? 1 : 0;
      4: res = a ^ o;
      5: res = x.sra ? 32'(int'(a) >>> sh) : a >> sh;
      6: res = a | o;
      default: res = a & o;
    endcase
    if (x.u) res = x.lui ? x.imm : x.pc + x.imm;
    if (x.j || x.jalr) res = x.pc + 4;
    if (x.b) res = 0;
    if (x.b)
      case (x.f3)
        0: tk = a == x.s2;
        1: tk = a != x.s2;
        4: tk = int'(a) < int'(x.s2);
        5: tk = int'(a) >= int'(x.s2);
        6: tk = a < x.s2;
        7: tk = a >= x.s2;
        default: tk = 0;
      endcase
    if (x.j || x.jalr) tk = 1;
    tgt = x.jalr ? ((a + x.imm) & 32'hFFFF_FFFE) : x.pc + x.imm;
    mp = (x.b || x.j || x.jalr) && (tk != x.pred || (tk && tgt != x.ptgt));
    rpc = tk ? tgt : x.pc + 4;
  endfunction
  function automatic logic [31:0] rv();
    return ($urandom % 4 == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
  endfunction
  function automatic instr_t rand_instr();
    instr_t x;
    logic [31:0] s1 = rv(), s2 = ($urandom % 3 == 0) ? s1 : rv(), pc = $urandom & 32'hFFFF_FFFC;
    logic [31:0] tg;
    logic [2:0] bf [6] = '{0, 1, 4, 5, 6, 7};
    case ($urandom % 7)
      0: x = mk_alu(1, 3'($urandom), s1, s2, 1'($urandom));
      1: x = mk_alu(0, 3'($urandom), s1, rv(), 1'($urandom));
      2: x = mk_u(1'($urandom), $urandom, pc);
      3, 4: x = mk_b(bf[$urandom % 6], s1, s2, pc, rv(), 1'($urandom), 0);
      5: x = mk_jmp(0, 0, rv(), pc, 1'($urandom), 0);
      default: x = mk_jmp(1, s1, rv(), pc, 1'($urandom), 0);
    endcase
    tg = x.jalr ? ((x.s1 + x.imm) & 32'hFFFF_FFFE) : x.pc + x.imm;
    x.ptgt = ($urandom % 2 == 0) ? tg : $urandom;
    x.id = 5'($urandom);
    return x;
  endfunction
  task automatic test_reset();
    rst_aL = 0; rob_wb_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (alu_broadcast_valid !== 0 || fetch_redirect_valid !== 0 || rob_wb_valid !== 0) begin errors++; $display("FAIL reset_valids got bv=%b rv=%b wv=%b exp 0", alu_broadcast_valid, fetch_redirect_valid, rob_wb_valid); end
    checks++; if (alu_broadcast_reg_data !== 0 || alu_broadcast_rob_id !== 0 || fetch_redirect_pc !== 0 || rob_wb_rob_id !== 0 || rob_wb_mispredict !== 0) begin errors++; $display("FAIL reset_data got data=%h id=%h rpc=%h wid=%h exp 0", alu_broadcast_reg_data, alu_broadcast_rob_id, fetch_redirect_pc, rob_wb_rob_id); end
    rst_aL = 1; #1;
    checks++; if (issue_ready !== 1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
  endtask
  task automatic test_alu();
    instr_t t [11] = '{mk_alu(1, 0, 5, 7, 0), mk_alu(1, 5, 32'h8000_0000, 4, 1), mk_alu(1, 5, 32'h8000_0000, 4, 0),
                       mk_alu(1, 0, 3, 5, 1), mk_alu(1, 2, 32'hFFFF_FFFF, 1, 0), mk_alu(1, 3, 32'hFFFF_FFFF, 1, 0),
                       mk_alu(1, 1, 1, 33, 0), mk_alu(0, 0, 10, 32'hFFFF_FFFD, 1), mk_alu(0, 4, 32'hF0F0, 32'h0FF0, 0),
                       mk_u(1, 32'h1234_5000, 32'h40), mk_u(0, 32'h2000, 32'h1000)};
    logic [31:0] ed [11] = '{12, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFE, 1, 0, 2, 7, 32'hFF00, 32'h1234_5000, 32'h3000};
    rob_wb_ready = 1;
    for (int k = 0; k < 11; k++) begin
      cur = t[k]; cur.id = 5'(k + 1); issue_valid = 1;
      @(posedge clk); #1;
      issue_valid = 0;
      checks++; if (alu_broadcast_valid !== 1 || alu_broadcast_reg_data !== ed[k] || alu_broadcast_rob_id !== 5'(k + 1)) begin errors++; $display("FAIL alu_%0d got v=%b data=%h id=%0d exp v=1 data=%h id=%0d", k, alu_broadcast_valid, alu_broadcast_reg_data, alu_broadcast_rob_id, ed[k], k + 1); end
      checks++; if (rob_wb_valid !== 1 || rob_wb_rob_id !== 5'(k + 1) || rob_wb_mispredict !== 0 || fetch_redirect_valid !== 0) begin errors++; $display("FAIL alu_wb_%0d got wv=%b wid=%0d mp=%b rv=%b", k, rob_wb_valid, rob_wb_rob_id, rob_wb_mispredict, fetch_redirect_valid); end
      @(posedge clk); #1;
      checks++; if (alu_broadcast_valid !== 0 || rob_wb_valid !== 0) begin errors++; $display("FAIL alu_pulse_%0d got bv=%b wv=%b exp 0", k, alu_broadcast_valid, rob_wb_valid); end
    end
  endtask
  task automatic test_branch();
    instr_t t [9] = '{mk_b(0, 3, 3, 32'h100, 32'h20, 0, 0), mk_b(0, 3, 3, 32'h100, 32'h20, 1, 32'h120),
                      mk_b(1, 3, 3, 32'h100, 32'h20, 1, 32'h120), mk_b(6, 1, 32'hFFFF_FFFF, 32'h200, 32'h40, 0, 0),
                      mk_b(4, 1, 32'hFFFF_FFFF, 32'h200, 32'h40, 0, 0),
                      mk_jmp(1, 32'h203, 4, 32'h40, 1, 32'h206), mk_jmp(1, 32'h203, 4, 32'h40, 1, 32'h200),
                      mk_jmp(0, 0, 32'hFFFF_FFF8, 32'h1000, 1, 32'hFF8), mk_jmp(0, 0, 32'hFFFF_FFF8, 32'h1000, 0, 0)};
    logic [31:0] ed [9] = '{0, 0, 0, 0, 0, 32'h44, 32'h44, 32'h1004, 32'h1004};
    logic er [9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
    logic [31:0] ep [9] = '{32'h120, 0, 32'h104, 32'h240, 0, 0, 32'h206, 0, 32'hFF8};
    rob_wb_ready = 1;
    for (int k = 0; k < 9; k++) begin
      cur = t[k]; cur.id = 5'(k + 16); issue_valid = 1;
      @(posedge clk); #1;
      issue_valid = 0;
      checks++; if (alu_broadcast_valid !== 1 || alu_broadcast_reg_data !== ed[k]) begin errors++; $display("FAIL br_data_%0d got v=%b data=%h exp v=1 data=%h", k, alu_broadcast_valid, alu_broadcast_reg_data, ed[k]); end
      checks++; if (fetch_redirect_valid !== er[k] || (er[k] && fetch_redirect_pc !== ep[k])) begin errors++; $display("FAIL br_redirect_%0d got v=%b pc=%h exp v=%b pc=%h", k, fetch_redirect_valid, fetch_redirect_pc, er[k], ep[k]); end
      checks++; if (rob_wb_valid !== 1 || rob_wb_mispredict !== er[k] || rob_wb_rob_id !== 5'(k + 16)) begin errors++; $display("FAIL br_wb_%0d got wv=%b mp=%b id=%0d exp mp=%b", k, rob_wb_valid, rob_wb_mispredict, rob_wb_rob_id, er[k]); end
      @(posedge clk); #1;
      checks++; if (fetch_redirect_valid !== 0) begin errors++; $display("FAIL br_pulse_%0d got rv=%b exp 0", k, fetch_redirect_valid); end
    end
  endtask
  task automatic test_back_to_back();
    rob_wb_ready = 0;
    cur = mk_alu(1, 0, 1, 1, 0); cur.id = 1; issue_valid = 1;
    @(posedge clk); #1;
    cur.id = 2;
    @(posedge clk); #1;
    issue_valid = 0;
    checks++; if (issue_ready !== 0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", issue_ready); end
    checks++; if (rob_wb_valid !== 1 || rob_wb_rob_id !== 1) begin errors++; $display("FAIL bp_head1 got v=%b id=%0d exp v=1 id=1", rob_wb_valid, rob_wb_rob_id); end
    rob_wb_ready = 1; #1;
    checks++; if (issue_ready !== 1) begin errors++; $display("FAIL bp_pop_ready got %b exp 1", issue_ready); end
    @(posedge clk); #1;
    checks++; if (rob_wb_valid !== 1 || rob_wb_rob_id !== 2) begin errors++; $display("FAIL bp_head2 got v=%b id=%0d exp v=1 id=2", rob_wb_valid, rob_wb_rob_id); end
    @(posedge clk); #1;
    checks++; if (rob_wb_valid !== 0) begin errors++; $display("FAIL bp_empty got %b exp 0", rob_wb_valid); end
  endtask
  task automatic test_flush();
    rob_wb_ready = 0;
    cur = mk_alu(1, 0, 2, 2, 0); cur.id = 5; issue_valid = 1;
    @(posedge clk); #1;
    cur = mk_b(0, 3, 3, 32'h100, 32'h20, 0, 0); cur.id = 6; flush = 1;
    checks++; if (alu_broadcast_valid !== 1 || alu_broadcast_rob_id !== 5) begin errors++; $display("FAIL flush_prior_bcast got v=%b id=%0d exp v=1 id=5", alu_broadcast_valid, alu_broadcast_rob_id); end
    @(posedge clk); #1;
    issue_valid = 0; flush = 0;
    checks++; if (alu_broadcast_valid !== 0 || fetch_redirect_valid !== 0) begin errors++; $display("FAIL flush_drop got bv=%b rv=%b exp 0", alu_broadcast_valid, fetch_redirect_valid); end
    checks++; if (rob_wb_valid !== 1 || rob_wb_rob_id !== 5) begin errors++; $display("FAIL flush_keep got v=%b id=%0d exp v=1 id=5", rob_wb_valid, rob_wb_rob_id); end
    rob_wb_ready = 1;
    @(posedge clk); #1;
    checks++; if (rob_wb_valid !== 0) begin errors++; $display("FAIL flush_no_push got %b exp 0", rob_wb_valid); end
  endtask
  task automatic test_reset_mid();
    rob_wb_ready = 0;
    cur = mk_b(0, 3, 3, 32'h100, 32'h20, 0, 0); cur.id = 7; issue_valid = 1;
    @(posedge clk); #1;
    cur.id = 8;
    @(posedge clk); #1;
    rst_aL = 0;
    @(posedge clk); #1;
    issue_valid = 0; rst_aL = 1;
    checks++; if (alu_broadcast_valid !== 0 || fetch_redirect_valid !== 0 || rob_wb_valid !== 0 || issue_ready !== 1) begin errors++; $display("FAIL midreset got bv=%b rv=%b wv=%b rdy=%b", alu_broadcast_valid, fetch_redirect_valid, rob_wb_valid, issue_ready); end
    checks++; if (alu_broadcast_reg_data !== 0 || fetch_redirect_pc !== 0 || rob_wb_rob_id !== 0) begin errors++; $display("FAIL midreset_data got data=%h rpc=%h wid=%h exp 0", alu_broadcast_reg_data, fetch_redirect_pc, rob_wb_rob_id); end
  endtask
  task automatic test_random(int n);
    wb_t q [$];
    logic ebv = 0, erv = 0, mp, mready, acc;
    logic [4:0] eid = 0;
    logic [31:0] edata = 0, erpc = 0, res, rpc;
    for (int k = 0; k < n; k++) begin
      checks++; if (alu_broadcast_valid !== ebv || (ebv && (alu_broadcast_rob_id !== eid || alu_broadcast_reg_data !== edata))) begin errors++; $display("FAIL rnd_bcast_%0d got v=%b id=%0d data=%h exp v=%b id=%0d data=%h", k, alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data, ebv, eid, edata); end
      checks++; if (fetch_redirect_valid !== erv || (erv && fetch_redirect_pc !== erpc)) begin errors++; $display("FAIL rnd_redirect_%0d got v=%b pc=%h exp v=%b pc=%h", k, fetch_redirect_valid, fetch_redirect_pc, erv, erpc); end
      cur = rand_instr();
      issue_valid = $urandom % 4 != 0; flush = $urandom % 8 == 0; rob_wb_ready = $urandom % 3 != 0;
      #1;
      mready = q.size() < 2 || rob_wb_ready;
      checks++; if (issue_ready !== mready) begin errors++; $display("FAIL rnd_ready_%0d got %b exp %b", k, issue_ready, mready); end
      checks++; if (rob_wb_valid !== (q.size() != 0) || (q.size() != 0 && (rob_wb_rob_id !== q[0].id || rob_wb_mispredict !== q[0].mp))) begin errors++; $display("FAIL rnd_wb_%0d got v=%b id=%0d mp=%b exp size=%0d", k, rob_wb_valid, rob_wb_rob_id, rob_wb_mispredict, q.size()); end
      acc = issue_valid && mready && !flush;
      if (q.size() != 0 && rob_wb_ready) void'(q.pop_front());
      ref_exec(cur, res, mp, rpc);
      ebv = acc; eid = cur.id; edata = res; erv = acc && mp; erpc = rpc;
      if (acc) q.push_back('{cur.id, mp});
      @(posedge clk); #1;
    end
    issue_valid = 0; flush = 0; rob_wb_ready = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random(2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
